// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with valid/ready handshaking on both sides.
// SKID=1 gives a head register plus a skid register so in_ready can come
// straight from a flop. SKID=0 collapses to a single pipeline register whose
// in_ready follows the classic "empty or draining" rule.
// All state changes on the falling edge of clk; rst is synchronous.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5,
    parameter int MTR_W  = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              RegWrite_in,
    input  logic [MTR_W-1:0]  MemtoReg_in,
    input  logic [DATA_W-1:0] D_MEM_read_data_in,
    input  logic [ADDR_W-1:0] D_MEM_read_addr_in,
    input  logic [RD_W-1:0]   EX_MEM_RegisterRd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWrite_out,
    output logic [MTR_W-1:0]  MemtoReg_out,
    output logic [DATA_W-1:0] D_MEM_read_data_out,
    output logic [ADDR_W-1:0] D_MEM_read_addr_out,
    output logic [RD_W-1:0]   MEM_WB_RegisterRd_out,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              regWrite;
        logic [MTR_W-1:0]  memtoReg;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [RD_W-1:0]   rd;
    } entryT;

    localparam bit UseSkid = (SKID != 0);

    entryT      inEntry;
    entryT      headQ, headD;
    entryT      skidQ, skidD;
    logic       headValidQ, headValidD;
    logic       skidValidQ, skidValidD;
    logic       inReadyQ, inReadyD;
    logic [1:0] occQ, occD;
    logic       inXfer, outXfer;

    // Bundle the incoming MEM-stage fields into one payload word.
    always_comb begin
        inEntry          = '0;
        inEntry.regWrite = RegWrite_in;
        inEntry.memtoReg = MemtoReg_in;
        inEntry.data     = D_MEM_read_data_in;
        inEntry.addr     = D_MEM_read_addr_in;
        inEntry.rd       = EX_MEM_RegisterRd_in;
    end

    // inReadyQ is low during reset in both modes; without the skid entry the
    // stage must also accept while the head drains, which needs out_ready.
    assign in_ready = UseSkid ? inReadyQ : (inReadyQ & (~headValidQ | out_ready));

    assign inXfer  = in_valid & in_ready;
    assign outXfer = headValidQ & out_ready;

    // Next-state for head/skid: flush wins, then drain skid, refill head, or park in skid.
    always_comb begin
        headD      = headQ;
        skidD      = skidQ;
        headValidD = headValidQ;
        skidValidD = skidValidQ;
        if (flush) begin
            headValidD = 1'b0;
            skidValidD = 1'b0;
        end else if (outXfer && skidValidQ) begin
            headD      = skidQ;
            skidValidD = 1'b0;
        end else if (!headValidQ || outXfer) begin
            headValidD = inXfer;
            if (inXfer) begin
                headD = inEntry;
            end
        end else if (inXfer) begin
            skidD      = inEntry;
            skidValidD = 1'b1;
        end
        inReadyD = ~skidValidD;
        occD     = {1'b0, headValidD} + {1'b0, skidValidD};
    end

    // Falling-edge state register with synchronous reset clearing everything.
    always_ff @(negedge clk) begin
        if (rst) begin
            headQ      <= '0;
            skidQ      <= '0;
            headValidQ <= 1'b0;
            skidValidQ <= 1'b0;
            inReadyQ   <= 1'b0;
            occQ       <= 2'd0;
        end else begin
            headQ      <= headD;
            skidQ      <= skidD;
            headValidQ <= headValidD;
            skidValidQ <= skidValidD;
            inReadyQ   <= inReadyD;
            occQ       <= occD;
        end
    end

    assign out_valid             = headValidQ;
    assign RegWrite_out          = headQ.regWrite & headValidQ;
    assign MemtoReg_out          = headQ.memtoReg;
    assign D_MEM_read_data_out   = headQ.data;
    assign D_MEM_read_addr_out   = headQ.addr;
    assign MEM_WB_RegisterRd_out = headQ.rd;
    assign occupancy             = occQ;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: one instance with the skid buffer and one without,
// driven by shared stimulus. Each instance has its own expected-entry queue
// that is filled on input handshakes and drained on output handshakes.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        RegWrite_in;
    logic [1:0]  MemtoReg_in;
    logic [31:0] D_MEM_read_data_in;
    logic [31:0] D_MEM_read_addr_in;
    logic [4:0]  EX_MEM_RegisterRd_in;
    logic        out_ready;

    logic        inReady1, outValid1, regWriteOut1;
    logic [1:0]  memtoRegOut1, occ1;
    logic [31:0] dataOut1, addrOut1;
    logic [4:0]  rdOut1;

    logic        inReady0, outValid0, regWriteOut0;
    logic [1:0]  memtoRegOut0, occ0;
    logic [31:0] dataOut0, addrOut0;
    logic [4:0]  rdOut0;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
    } entryT;

    entryT q1[$];
    entryT q0[$];
    entryT popped1, popped0, offered;

    mem_wb_stage #(.SKID(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady1), .flush(flush),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .D_MEM_read_data_in(D_MEM_read_data_in), .D_MEM_read_addr_in(D_MEM_read_addr_in),
        .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in), .out_valid(outValid1), .out_ready(out_ready),
        .RegWrite_out(regWriteOut1), .MemtoReg_out(memtoRegOut1),
        .D_MEM_read_data_out(dataOut1), .D_MEM_read_addr_out(addrOut1),
        .MEM_WB_RegisterRd_out(rdOut1), .occupancy(occ1)
    );

    mem_wb_stage #(.SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady0), .flush(flush),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .D_MEM_read_data_in(D_MEM_read_data_in), .D_MEM_read_addr_in(D_MEM_read_addr_in),
        .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in), .out_valid(outValid0), .out_ready(out_ready),
        .RegWrite_out(regWriteOut0), .MemtoReg_out(memtoRegOut0),
        .D_MEM_read_data_out(dataOut0), .D_MEM_read_addr_out(addrOut0),
        .MEM_WB_RegisterRd_out(rdOut0), .occupancy(occ0)
    );

    // Free-running clock; the DUT updates on the falling edge.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] data,
                                 input logic oready, input logic fl);
        in_valid             = v;
        EX_MEM_RegisterRd_in = rd;
        D_MEM_read_data_in   = data;
        D_MEM_read_addr_in   = 32'h1000_0000 + {27'd0, rd};
        MemtoReg_in          = rd[1:0];
        RegWrite_in          = 1'b1;
        out_ready            = oready;
        flush                = fl;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: at mid-cycle, compare heads leaving each DUT and record accepted inputs.
    always @(posedge clk) begin
        offered.rd   = EX_MEM_RegisterRd_in;
        offered.data = D_MEM_read_data_in;
        offered.addr = D_MEM_read_addr_in;
        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (outValid1 && out_ready) begin
                if (q1.size() == 0) begin
                    checkOutput("sb1Unexpected", 64'(rdOut1), 64'hFFFF);
                end else begin
                    popped1 = q1.pop_front();
                    checkOutput("sb1Rd", 64'(rdOut1), 64'(popped1.rd));
                    checkOutput("sb1Data", 64'(dataOut1), 64'(popped1.data));
                    checkOutput("sb1Addr", 64'(addrOut1), 64'(popped1.addr));
                    checkOutput("sb1RegWrite", 64'(regWriteOut1), 64'd1);
                end
            end
            if (outValid0 && out_ready) begin
                if (q0.size() == 0) begin
                    checkOutput("sb0Unexpected", 64'(rdOut0), 64'hFFFF);
                end else begin
                    popped0 = q0.pop_front();
                    checkOutput("sb0Rd", 64'(rdOut0), 64'(popped0.rd));
                    checkOutput("sb0Data", 64'(dataOut0), 64'(popped0.data));
                end
            end
            if (in_valid && inReady1) q1.push_back(offered);
            if (in_valid && inReady0) q0.push_back(offered);
        end
    end

    // Directed sequence: reset, stream, stall, flush, bubble, reset mid-stall, single-register mode.
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rstOutValid", 64'(outValid1), 64'd0);
        checkOutput("rstOcc", 64'(occ1), 64'd0);
        checkOutput("rstInReady1", 64'(inReady1), 64'd0);
        checkOutput("rstInReady0", 64'(inReady0), 64'd0);
        checkOutput("rstData", 64'(dataOut1), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("postRstInReady1", 64'(inReady1), 64'd1);
        checkOutput("postRstInReady0", 64'(inReady0), 64'd1);

        // Stream Rd=1,2,3 with the consumer always ready.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 5'(i), 32'hA000_0000 | i, 1'b1, 1'b0);
            tick();
            checkOutput("streamRd", 64'(rdOut1), 64'(i));
            checkOutput("streamValid", 64'(outValid1), 64'd1);
            checkOutput("streamOcc", 64'(occ1), 64'd1);
            checkOutput("streamInReady", 64'(inReady1), 64'd1);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("streamDrained", 64'(outValid1), 64'd0);

        // Stall: Rd=4 held, Rd=5 parks in skid, Rd=6 refused.
        applyStimulus(1'b1, 5'd4, 32'hA000_0004, 1'b0, 1'b0);
        tick();
        checkOutput("stallOcc1", 64'(occ1), 64'd1);
        applyStimulus(1'b1, 5'd5, 32'hA000_0005, 1'b0, 1'b0);
        tick();
        checkOutput("stallOcc2", 64'(occ1), 64'd2);
        checkOutput("stallInReady", 64'(inReady1), 64'd0);
        applyStimulus(1'b1, 5'd6, 32'hA000_0006, 1'b0, 1'b0);
        tick();
        checkOutput("stallHoldRd", 64'(rdOut1), 64'd4);
        checkOutput("stallHoldData", 64'(dataOut1), 64'hA000_0004);
        checkOutput("stallOccStill2", 64'(occ1), 64'd2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("releaseRd5", 64'(rdOut1), 64'd5);
        checkOutput("releaseInReady", 64'(inReady1), 64'd1);
        tick();
        checkOutput("releaseEmpty", 64'(outValid1), 64'd0);

        // Flush with two held entries and a simultaneous offer of Rd=7.
        applyStimulus(1'b1, 5'd8, 32'hA000_0008, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd9, 32'hA000_0009, 1'b0, 1'b0);
        tick();
        checkOutput("preFlushOcc", 64'(occ1), 64'd2);
        applyStimulus(1'b1, 5'd7, 32'hA000_0007, 1'b0, 1'b1);
        tick();
        checkOutput("flushOcc", 64'(occ1), 64'd0);
        checkOutput("flushValid", 64'(outValid1), 64'd0);
        checkOutput("flushRegWrite", 64'(regWriteOut1), 64'd0);
        checkOutput("flushPayloadKept", 64'(rdOut1), 64'd8);
        checkOutput("flushInReady", 64'(inReady1), 64'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("flushNoRd7", 64'(outValid1), 64'd0);

        // Bubble: entry with RegWrite consumed, nothing follows.
        applyStimulus(1'b1, 5'd10, 32'hA000_000A, 1'b1, 1'b0);
        tick();
        checkOutput("bubbleLoaded", 64'(regWriteOut1), 64'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("bubbleValid", 64'(outValid1), 64'd0);
        checkOutput("bubbleRegWrite", 64'(regWriteOut1), 64'd0);
        checkOutput("bubbleRegWrite0", 64'(regWriteOut0), 64'd0);
        checkOutput("bubblePayload", 64'(dataOut1), 64'hA000_000A);

        // Reset while stalled with 0xDEADBEEF at the head.
        applyStimulus(1'b1, 5'd11, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("heldDeadbeef", 64'(dataOut1), 64'hDEAD_BEEF);
        rst = 1'b1;
        tick();
        checkOutput("midRstData", 64'(dataOut1), 64'd0);
        checkOutput("midRstAddr", 64'(addrOut1), 64'd0);
        checkOutput("midRstRd", 64'(rdOut1), 64'd0);
        checkOutput("midRstMtr", 64'(memtoRegOut1), 64'd0);
        checkOutput("midRstValid", 64'(outValid1), 64'd0);
        checkOutput("midRstOcc", 64'(occ1), 64'd0);
        checkOutput("midRstInReady", 64'(inReady1), 64'd0);
        checkOutput("midRstInReady0", 64'(inReady0), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("afterRstInReady", 64'(inReady1), 64'd1);

        // Single-register mode: back-pressure then one-per-edge throughput.
        applyStimulus(1'b1, 5'd12, 32'hA000_000C, 1'b0, 1'b0);
        tick();
        checkOutput("s0Loaded", 64'(rdOut0), 64'd12);
        checkOutput("s0InReadyFull", 64'(inReady0), 64'd0);
        applyStimulus(1'b1, 5'd13, 32'hA000_000D, 1'b0, 1'b0);
        #1;
        checkOutput("s0RefuseReady", 64'(inReady0), 64'd0);
        tick();
        checkOutput("s0HoldRd", 64'(rdOut0), 64'd12);
        applyStimulus(1'b1, 5'd14, 32'hA000_000E, 1'b1, 1'b0);
        #1;
        checkOutput("s0DrainReady", 64'(inReady0), 64'd1);
        tick();
        checkOutput("s0Rd14", 64'(rdOut0), 64'd14);
        checkOutput("s0Occ", 64'(occ0), 64'd1);
        applyStimulus(1'b1, 5'd15, 32'hA000_000F, 1'b1, 1'b0);
        tick();
        checkOutput("s0Rd15", 64'(rdOut0), 64'd15);

        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("finalEmpty1", 64'(outValid1), 64'd0);
        checkOutput("finalEmpty0", 64'(outValid0), 64'd0);
        checkOutput("sb1Leftover", 64'(q1.size()), 64'd0);
        checkOutput("sb0Leftover", 64'(q0.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
